// File: rtl/id_decode_stage_pkg.sv
// Shared encodings and decoded-bundle types for the instruction decode stage.
package id_decode_stage_pkg;

    // Primary opcode field, instr[31:26].
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h08,
        OP_SUBI  = 6'h09,
        OP_LLI   = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_SWR   = 6'h2B
    } opcode_t;

    // R-type function field, instr[5:0].
    typedef enum logic [5:0] {
        FN_SLL = 6'h00,
        FN_SLA = 6'h01,
        FN_SRL = 6'h02,
        FN_SRA = 6'h03,
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_XOR = 6'h26
    } func_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLA = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_t;

    // Everything the ALU/register-file stage needs from one instruction.
    typedef struct packed {
        alu_op_t     alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wdest;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        mem_write;
        logic        illegal;
    } decoded_t;

    // The all-zero word is the canonical no-operation.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/id_decode_stage_field_decoder.sv
// Purely combinational field split and control decode of one instruction word.
// Illegal words produce no side effects: no write, no store, no source use.
module inst_field_decoder
    import id_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec,
    output logic        rs_used,
    output logic        rt_used
);

    logic imm_write;

    // Decode opcode/func into the bundle, then apply the illegal and r0 overrides.
    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.rs     = instr[25:21];
        dec.rt     = instr[20:16];
        rs_used    = 1'b0;
        rt_used    = 1'b0;
        imm_write  = 1'b0;

        if (instr != NOP_WORD) begin
            case (instr[31:26])
                OP_RTYPE: begin
                    dec.wdest     = instr[15:11];
                    dec.reg_write = 1'b1;
                    rs_used       = 1'b1;
                    rt_used       = 1'b1;
                    case (instr[5:0])
                        FN_ADD: dec.alu_op = ALU_ADD;
                        FN_SUB: dec.alu_op = ALU_SUB;
                        FN_AND: dec.alu_op = ALU_AND;
                        FN_OR:  dec.alu_op = ALU_OR;
                        FN_XOR: dec.alu_op = ALU_XOR;
                        // Shifts take their amount from sa; the rs field is don't-care.
                        FN_SLL: begin dec.alu_op = ALU_SLL; dec.shamt = instr[10:6]; rs_used = 1'b0; end
                        FN_SRL: begin dec.alu_op = ALU_SRL; dec.shamt = instr[10:6]; rs_used = 1'b0; end
                        FN_SLA: begin dec.alu_op = ALU_SLA; dec.shamt = instr[10:6]; rs_used = 1'b0; end
                        FN_SRA: begin dec.alu_op = ALU_SRA; dec.shamt = instr[10:6]; rs_used = 1'b0; end
                        default: dec.illegal = 1'b1;
                    endcase
                end
                OP_ADDI: begin dec.alu_op = ALU_ADD; dec.imm = sign_ext16(instr[15:0]); rs_used = 1'b1; imm_write = 1'b1; end
                OP_SUBI: begin dec.alu_op = ALU_SUB; dec.imm = sign_ext16(instr[15:0]); rs_used = 1'b1; imm_write = 1'b1; end
                OP_ANDI: begin dec.alu_op = ALU_AND; dec.imm = zero_ext16(instr[15:0]); rs_used = 1'b1; imm_write = 1'b1; end
                OP_ORI:  begin dec.alu_op = ALU_OR;  dec.imm = zero_ext16(instr[15:0]); rs_used = 1'b1; imm_write = 1'b1; end
                OP_XORI: begin dec.alu_op = ALU_XOR; dec.imm = zero_ext16(instr[15:0]); rs_used = 1'b1; imm_write = 1'b1; end
                // LUI/LLI build the whole constant in imm; operand A is not read.
                OP_LUI:  begin dec.alu_op = ALU_ADD; dec.imm = {instr[15:0], 16'h0000}; imm_write = 1'b1; end
                OP_LLI:  begin dec.alu_op = ALU_ADD; dec.imm = zero_ext16(instr[15:0]); imm_write = 1'b1; end
                OP_SWR: begin
                    dec.alu_op    = ALU_ADD;
                    dec.imm       = sign_ext16(instr[15:0]);
                    dec.use_imm   = 1'b1;
                    dec.mem_write = 1'b1;
                    rs_used       = 1'b1;
                    rt_used       = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end

        if (imm_write) begin
            dec.use_imm   = 1'b1;
            dec.wdest     = instr[20:16];
            dec.reg_write = 1'b1;
        end

        if (dec.illegal) begin
            dec.wdest     = 5'd0;
            dec.reg_write = 1'b0;
            dec.mem_write = 1'b0;
            rs_used       = 1'b0;
            rt_used       = 1'b0;
        end

        // r0 is never written.
        if (dec.wdest == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage: one bundle register behind a valid/ready handshake,
// a short history of write destinations for RAW flagging, and statistics.
//
// Handshake: an input transfer happens when in_valid && in_ready && !flush;
// an output transfer happens when out_valid && out_ready. in_ready is
// !out_valid || out_ready, so a new word may replace a departing bundle in the
// same cycle. While out_valid && !out_ready the bundle is held unchanged.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int HAZ_DEPTH = 2,
    parameter int CNT_W     = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_op_t          out_alu_op,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_wdest,
    output logic [4:0]       out_shamt,
    output logic [31:0]      out_imm,
    output logic             out_use_imm,
    output logic             out_reg_write,
    output logic             out_mem_write,
    output logic             out_illegal,
    output logic             out_raw_hazard,
    output logic [CNT_W-1:0] decoded_count,
    output logic [CNT_W-1:0] illegal_count
);

    decoded_t   dec;
    decoded_t   bundle;
    logic       rs_used;
    logic       rt_used;
    logic       hazard;
    logic       raw_q;
    logic       valid_q;
    logic       accept;
    logic [4:0] hist [HAZ_DEPTH];

    inst_field_decoder u_field_decoder (
        .instr   (in_instr),
        .dec     (dec),
        .rs_used (rs_used),
        .rt_used (rt_used)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Compare used, non-zero sources against history as it stood before this word.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist[i] != 5'd0) begin
                if (rs_used && (dec.rs == hist[i])) hazard = 1'b1;
                if (rt_used && (dec.rt == hist[i])) hazard = 1'b1;
            end
        end
    end

    // Bundle register: flush beats accept, accept beats drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            bundle  <= '0;
            raw_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            bundle  <= dec;
            raw_q   <= hazard;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Destination history: newest in slot 0, shifted on every accepted word.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < HAZ_DEPTH; i++) hist[i] <= 5'd0;
        end else if (accept) begin
            hist[0] <= dec.wdest;
            for (int i = 1; i < HAZ_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    // Statistics: total count wraps, illegal count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            decoded_count <= '0;
            illegal_count <= '0;
        end else if (accept) begin
            decoded_count <= decoded_count + CNT_W'(1);
            if (dec.illegal && (illegal_count != '1)) begin
                illegal_count <= illegal_count + CNT_W'(1);
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_alu_op     = bundle.alu_op;
    assign out_rs         = bundle.rs;
    assign out_rt         = bundle.rt;
    assign out_wdest      = bundle.wdest;
    assign out_shamt      = bundle.shamt;
    assign out_imm        = bundle.imm;
    assign out_use_imm    = bundle.use_imm;
    assign out_reg_write  = bundle.reg_write;
    assign out_mem_write  = bundle.mem_write;
    assign out_illegal    = bundle.illegal;
    assign out_raw_hazard = raw_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed scenarios plus randomized traffic,
// scored against a behavioural reference model through an expected queue.
module tb_id_decode_stage;
    import id_decode_stage_pkg::*;

    localparam int HAZ_DEPTH = 2;
    localparam int CNT_W     = 4;
    localparam int EW        = $bits(decoded_t) + 1;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    alu_op_t          out_alu_op;
    logic [4:0]       out_rs, out_rt, out_wdest, out_shamt;
    logic [31:0]      out_imm;
    logic             out_use_imm, out_reg_write, out_mem_write, out_illegal, out_raw_hazard;
    logic [CNT_W-1:0] decoded_count, illegal_count;

    always #5 clk = ~clk;

    id_decode_stage #(.HAZ_DEPTH(HAZ_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_rs(out_rs), .out_rt(out_rt), .out_wdest(out_wdest), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_use_imm(out_use_imm), .out_reg_write(out_reg_write),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal), .out_raw_hazard(out_raw_hazard),
        .decoded_count(decoded_count), .illegal_count(illegal_count)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] r_word(input logic [5:0] fn, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sa);
        return {6'(OP_RTYPE), rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ---------------- reference model ----------------
    // Meaning of each instruction class, written from the ISA description.
    function automatic void model_decode(input logic [31:0] w, output decoded_t d,
                                         output bit ru, output bit tu);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx;
        logic [31:0] zx;
        bit          shift;
        op = w[31:26];
        fn = w[5:0];
        sx = 32'($signed(w[15:0]));
        zx = 32'(w[15:0]);
        shift = 1'b0;
        d = '0;
        d.alu_op = ALU_ADD;
        d.rs = w[25:21];
        d.rt = w[20:16];
        ru = 0;
        tu = 0;
        if (w == 32'h0) return;
        if (op == OP_RTYPE) begin
            if      (fn == FN_ADD) d.alu_op = ALU_ADD;
            else if (fn == FN_SUB) d.alu_op = ALU_SUB;
            else if (fn == FN_AND) d.alu_op = ALU_AND;
            else if (fn == FN_OR)  d.alu_op = ALU_OR;
            else if (fn == FN_XOR) d.alu_op = ALU_XOR;
            else if (fn == FN_SLL) begin d.alu_op = ALU_SLL; shift = 1; end
            else if (fn == FN_SRL) begin d.alu_op = ALU_SRL; shift = 1; end
            else if (fn == FN_SLA) begin d.alu_op = ALU_SLA; shift = 1; end
            else if (fn == FN_SRA) begin d.alu_op = ALU_SRA; shift = 1; end
            else d.illegal = 1;
            if (!d.illegal) begin
                d.wdest = w[15:11];
                d.reg_write = (w[15:11] != 0);
                d.shamt = shift ? w[10:6] : 5'd0;
                ru = !shift;
                tu = 1;
            end
        end else if (op == OP_SWR) begin
            d.imm = sx; d.use_imm = 1; d.mem_write = 1; ru = 1; tu = 1;
        end else begin
            if      (op == OP_ADDI) begin d.alu_op = ALU_ADD; d.imm = sx; end
            else if (op == OP_SUBI) begin d.alu_op = ALU_SUB; d.imm = sx; end
            else if (op == OP_ANDI) begin d.alu_op = ALU_AND; d.imm = zx; end
            else if (op == OP_ORI)  begin d.alu_op = ALU_OR;  d.imm = zx; end
            else if (op == OP_XORI) begin d.alu_op = ALU_XOR; d.imm = zx; end
            else if (op == OP_LUI)  d.imm = {w[15:0], 16'h0};
            else if (op == OP_LLI)  d.imm = zx;
            else d.illegal = 1;
            if (!d.illegal) begin
                d.use_imm = 1;
                d.wdest = w[20:16];
                d.reg_write = (w[20:16] != 0);
                ru = (op != OP_LUI) && (op != OP_LLI);
            end
        end
    endfunction

    logic [EW-1:0] exp_q[$];
    logic [4:0]    hist_q[$];
    bit            m_valid = 0;
    int            m_dec_cnt = 0;
    int            m_ill_cnt = 0;

    // Model: tracks what the stage should be holding after each edge.
    always @(posedge clk) begin
        decoded_t d;
        bit ru, tu, haz, acc;
        if (rst) begin
            m_valid = 0; m_dec_cnt = 0; m_ill_cnt = 0;
            hist_q.delete(); exp_q.delete();
        end else if (flush) begin
            m_valid = 0;
            hist_q.delete(); exp_q.delete();
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                model_decode(in_instr, d, ru, tu);
                haz = 0;
                foreach (hist_q[i]) begin
                    if (hist_q[i] != 0 && ((ru && d.rs == hist_q[i]) || (tu && d.rt == hist_q[i])))
                        haz = 1;
                end
                hist_q.push_front(d.wdest);
                if (hist_q.size() > HAZ_DEPTH) void'(hist_q.pop_back());
                exp_q.push_back({haz, d});
                m_dec_cnt = (m_dec_cnt + 1) % (CNT_MAX + 1);
                if (d.illegal && m_ill_cnt < CNT_MAX) m_ill_cnt++;
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        decoded_t d;
        logic     h;
        if (!rst) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("decoded_count", 32'(decoded_count), 32'(m_dec_cnt));
            check("illegal_count", 32'(illegal_count), 32'(m_ill_cnt));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 32'(0), 32'(1));
                end else begin
                    {h, d} = exp_q[0];
                    check("alu_op", 32'(out_alu_op), 32'(d.alu_op));
                    check("rs", 32'(out_rs), 32'(d.rs));
                    check("rt", 32'(out_rt), 32'(d.rt));
                    check("wdest", 32'(out_wdest), 32'(d.wdest));
                    check("shamt", 32'(out_shamt), 32'(d.shamt));
                    check("imm", out_imm, d.imm);
                    check("use_imm", 32'(out_use_imm), 32'(d.use_imm));
                    check("reg_write", 32'(out_reg_write), 32'(d.reg_write));
                    check("mem_write", 32'(out_mem_write), 32'(d.mem_write));
                    check("illegal", 32'(out_illegal), 32'(d.illegal));
                    check("raw_hazard", 32'(out_raw_hazard), 32'(h));
                    if (out_ready && !flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        int k;
        logic [4:0] a, b, c, s;
        logic [15:0] imm;
        k = $urandom_range(0, 21);
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        s = 5'($urandom);
        imm = 16'($urandom);
        case (k)
            0:  return r_word(FN_ADD, a, b, c, s);
            1:  return r_word(FN_SUB, a, b, c, s);
            2:  return r_word(FN_AND, a, b, c, s);
            3:  return r_word(FN_OR,  a, b, c, s);
            4:  return r_word(FN_XOR, a, b, c, s);
            5:  return r_word(FN_SLL, a, b, c, s);
            6:  return r_word(FN_SRL, a, b, c, s);
            7:  return r_word(FN_SLA, a, b, c, s);
            8:  return r_word(FN_SRA, a, b, c, s);
            9:  return i_word(OP_ADDI, a, b, imm);
            10: return i_word(OP_SUBI, a, b, imm);
            11: return i_word(OP_ANDI, a, b, imm);
            12: return i_word(OP_ORI,  a, b, imm);
            13: return i_word(OP_XORI, a, b, imm);
            14: return i_word(OP_LUI,  a, b, imm);
            15: return i_word(OP_LLI,  a, b, imm);
            16: return i_word(OP_SWR,  a, b, imm);
            17: return 32'h0;
            18: return r_word(6'h3F, a, b, c, s);
            19: return i_word(6'h3E, a, b, imm);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w_a, w_b, w_c;
        int saved;

        rst = 1; in_valid = 0; in_instr = 0; out_ready = 0; flush = 0;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_imm", out_imm, 32'h0);
        check("rst_wdest", 32'(out_wdest), 32'(0));
        check("rst_reg_write", 32'(out_reg_write), 32'(0));
        check("rst_decoded_count", 32'(decoded_count), 32'(0));
        check("rst_illegal_count", 32'(illegal_count), 32'(0));
        @(posedge clk); #1;
        rst = 0;

        // ADD r10 = r2 + r4
        step(1, r_word(FN_ADD, 2, 4, 10, 0), 1, 0);
        check("add_valid", 32'(out_valid), 32'(1));
        check("add_alu", 32'(out_alu_op), 32'(ALU_ADD));
        check("add_wdest", 32'(out_wdest), 32'(10));
        check("add_reg_write", 32'(out_reg_write), 32'(1));
        check("add_haz", 32'(out_raw_hazard), 32'(0));
        check("add_count", 32'(decoded_count), 32'(1));

        // Sign-extended SUBI, then LUI whose rs is ignored
        step(1, i_word(OP_SUBI, 9, 10, 16'hFFFB), 1, 0);
        check("subi_imm", out_imm, 32'hFFFF_FFFB);
        check("subi_use_imm", 32'(out_use_imm), 32'(1));
        check("subi_alu", 32'(out_alu_op), 32'(ALU_SUB));
        step(1, i_word(OP_LUI, 10, 3, 16'h0008), 1, 0);
        check("lui_imm", out_imm, 32'h0008_0000);
        check("lui_haz", 32'(out_raw_hazard), 32'(0));
        check("lui_wdest", 32'(out_wdest), 32'(3));

        // RAW inside and outside the history window
        step(1, i_word(OP_ADDI, 0, 10, 16'h0001), 1, 0);
        step(1, r_word(FN_ADD, 10, 0, 5, 0), 1, 0);
        check("raw_near", 32'(out_raw_hazard), 32'(1));
        step(1, i_word(OP_ADDI, 0, 10, 16'h0001), 1, 0);
        step(1, i_word(OP_ORI, 0, 11, 16'h00F0), 1, 0);
        step(1, i_word(OP_XORI, 0, 12, 16'h8000), 1, 0);
        check("xori_imm", out_imm, 32'h0000_8000);
        step(1, r_word(FN_ADD, 10, 0, 5, 0), 1, 0);
        check("raw_aged_out", 32'(out_raw_hazard), 32'(0));

        // Backpressure hold and no-bubble release
        w_a = r_word(FN_ADD, 1, 2, 7, 0);
        w_b = r_word(FN_SUB, 1, 2, 8, 0);
        w_c = r_word(FN_OR, 3, 3, 9, 0);
        step(1, w_a, 1, 0);
        saved = m_dec_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1, w_b, 0, 0);
            check("hold_in_ready", 32'(in_ready), 32'(0));
            check("hold_wdest", 32'(out_wdest), 32'(7));
        end
        check("hold_count", 32'(decoded_count), 32'(saved));
        step(1, w_b, 1, 0);
        check("release_wdest", 32'(out_wdest), 32'(8));
        check("release_count", 32'(decoded_count), 32'((saved + 1) % (CNT_MAX + 1)));
        step(1, w_c, 1, 0);
        check("next_wdest", 32'(out_wdest), 32'(9));

        // Illegal opcode, then NOP
        step(1, {6'h3F, 26'h0123456}, 1, 0);
        check("illegal_flag", 32'(out_illegal), 32'(1));
        check("illegal_reg_write", 32'(out_reg_write), 32'(0));
        check("illegal_count1", 32'(illegal_count), 32'(1));
        step(1, 32'h0, 1, 0);
        check("nop_illegal", 32'(out_illegal), 32'(0));
        check("nop_alu", 32'(out_alu_op), 32'(ALU_ADD));
        check("nop_reg_write", 32'(out_reg_write), 32'(0));
        check("nop_illegal_count", 32'(illegal_count), 32'(1));

        // Flush wins over accept and clears history
        step(1, i_word(OP_ADDI, 0, 10, 16'h0002), 1, 0);
        saved = m_dec_cnt;
        step(1, r_word(FN_ADD, 1, 1, 1, 0), 1, 1);
        check("flush_valid", 32'(out_valid), 32'(0));
        check("flush_count", 32'(decoded_count), 32'(saved));
        step(1, r_word(FN_ADD, 10, 0, 6, 0), 1, 0);
        check("flush_hist_clear", 32'(out_raw_hazard), 32'(0));

        // Reset while a bundle is stalled
        step(1, r_word(FN_ADD, 1, 2, 3, 0), 0, 0);
        step(1, r_word(FN_ADD, 1, 2, 4, 0), 0, 0);
        rst = 1;
        step(1, r_word(FN_ADD, 1, 2, 4, 0), 0, 0);
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_count", 32'(decoded_count), 32'(0));
        rst = 0;
        step(0, 32'h0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end
        rst = 0;
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
